// File: rtl/ex_wb_buffer.sv
// ex_wb_buffer: two-entry elastic buffer between execute and register-file writeback,
// with two combinational forwarding lookup ports over the pending entries.
module ex_wb_buffer #(
    parameter int DATA_WIDTH  = 32,
    parameter int RADDR_WIDTH = 5,
    parameter int DEPTH       = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic                   reg_we_i,
    input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
    input  logic [DATA_WIDTH-1:0]  reg_wdata_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic                   reg_we_o,
    output logic [RADDR_WIDTH-1:0] reg_waddr_o,
    output logic [DATA_WIDTH-1:0]  reg_wdata_o,
    input  logic [RADDR_WIDTH-1:0] fwd_raddr1_i,
    output logic                   fwd_hit1_o,
    output logic [DATA_WIDTH-1:0]  fwd_data1_o,
    input  logic [RADDR_WIDTH-1:0] fwd_raddr2_i,
    output logic                   fwd_hit2_o,
    output logic [DATA_WIDTH-1:0]  fwd_data2_o,
    output logic [1:0]             count_o
);
    logic                   we_q    [DEPTH];
    logic [RADDR_WIDTH-1:0] waddr_q [DEPTH];
    logic [DATA_WIDTH-1:0]  data_q  [DEPTH];
    logic                   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]             count_q, count_d;
    logic                   push, pop, young, old;

    assign in_ready_o  = count_q != 2'd2;
    assign out_valid_o = count_q != 2'd0;
    assign count_o     = count_q;
    // Youngest entry sits just behind the write pointer; the other slot is only live when full.
    assign young       = ~wr_ptr_q;
    assign old         = wr_ptr_q;

    always_comb begin
        push     = in_valid_i & in_ready_o;
        pop      = out_valid_o & out_ready_i;
        wr_ptr_d = flush_i ? 1'b0 : wr_ptr_q ^ push;
        rd_ptr_d = flush_i ? 1'b0 : rd_ptr_q ^ pop;
        count_d  = flush_i ? 2'd0 : count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            for (int i = 0; i < DEPTH; i++) begin
                we_q[i]    <= 1'b0;
                waddr_q[i] <= '0;
                data_q[i]  <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push && !flush_i) begin
                we_q[wr_ptr_q]    <= reg_we_i & (|reg_waddr_i);
                waddr_q[wr_ptr_q] <= reg_waddr_i;
                data_q[wr_ptr_q]  <= reg_wdata_i;
            end
        end
    end

    assign reg_we_o    = out_valid_o & we_q[rd_ptr_q];
    assign reg_waddr_o = out_valid_o ? waddr_q[rd_ptr_q] : '0;
    assign reg_wdata_o = out_valid_o ? data_q[rd_ptr_q] : '0;

    // x0 is stored with we cleared, so an address-0 lookup can never hit.
    function automatic logic [DATA_WIDTH:0] lookup(input logic [RADDR_WIDTH-1:0] a);
        logic hy, ho;
        hy = (count_q != 2'd0) && we_q[young] && (waddr_q[young] == a);
        ho = (count_q == 2'd2) && we_q[old] && (waddr_q[old] == a);
        return hy ? {1'b1, data_q[young]} : ho ? {1'b1, data_q[old]} : '0;
    endfunction

    assign {fwd_hit1_o, fwd_data1_o} = lookup(fwd_raddr1_i);
    assign {fwd_hit2_o, fwd_data2_o} = lookup(fwd_raddr2_i);
endmodule

// File: tb/tb_ex_wb_buffer.sv
// tb_ex_wb_buffer: directed vectors with hand-computed expectations for ex_wb_buffer.
module tb_ex_wb_buffer;
    logic        clk_i = 1'b0, rst_i = 1'b0, flush_i = 1'b0;
    logic        in_valid_i = 1'b0, in_ready_o, reg_we_i = 1'b0;
    logic [4:0]  reg_waddr_i = '0;
    logic [31:0] reg_wdata_i = '0;
    logic        out_valid_o, out_ready_i = 1'b0, reg_we_o;
    logic [4:0]  reg_waddr_o, fwd_raddr1_i = '0, fwd_raddr2_i = '0;
    logic [31:0] reg_wdata_o, fwd_data1_o, fwd_data2_o;
    logic        fwd_hit1_o, fwd_hit2_o;
    logic [1:0]  count_o;
    int          n_chk = 0, n_err = 0;

    ex_wb_buffer dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .reg_we_i(reg_we_i), .reg_waddr_i(reg_waddr_i), .reg_wdata_i(reg_wdata_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o),
        .fwd_raddr1_i(fwd_raddr1_i), .fwd_hit1_o(fwd_hit1_o), .fwd_data1_o(fwd_data1_o),
        .fwd_raddr2_i(fwd_raddr2_i), .fwd_hit2_o(fwd_hit2_o), .fwd_data2_o(fwd_data2_o),
        .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic [4:0] a, input logic [31:0] d);
        in_valid_i  = v;
        reg_we_i    = we;
        reg_waddr_i = a;
        reg_wdata_i = d;
    endtask

    initial begin
        drive(1'b1, 1'b1, 5'd5, 32'hAA);
        fwd_raddr1_i = 5'd5;
        #3;
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_in_ready", in_ready_o, 1);
        chk("rst_count", count_o, 0);
        chk("rst_reg_we", reg_we_o, 0);
        chk("rst_wdata", reg_wdata_o, 0);
        chk("rst_fwd_hit", fwd_hit1_o, 0);
        rst_i = 1'b1;
        out_ready_i = 1'b1;
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0);
        chk("first_valid", out_valid_o, 1);
        chk("first_waddr", reg_waddr_o, 5);
        chk("first_wdata", reg_wdata_o, 32'hAA);
        chk("first_we", reg_we_o, 1);
        chk("first_fwd_hit", fwd_hit1_o, 1);
        chk("first_fwd_data", fwd_data1_o, 32'hAA);
        tick();
        chk("first_popped", out_valid_o, 0);
        chk("first_count0", count_o, 0);

        out_ready_i = 1'b0;
        drive(1'b1, 1'b1, 5'd1, 32'h11); tick();
        drive(1'b1, 1'b1, 5'd2, 32'h22); tick();
        chk("full_count", count_o, 2);
        chk("full_in_ready", in_ready_o, 0);
        drive(1'b1, 1'b1, 5'd3, 32'h33); tick();
        chk("ignored_count", count_o, 2);
        chk("stall_head_waddr", reg_waddr_o, 1);
        chk("stall_head_wdata", reg_wdata_o, 32'h11);
        drive(1'b0, 1'b0, 5'd0, 32'h0);
        out_ready_i = 1'b1;
        tick();
        chk("order2_waddr", reg_waddr_o, 2);
        chk("order2_wdata", reg_wdata_o, 32'h22);
        chk("order2_count", count_o, 1);
        tick();
        chk("drain_count", count_o, 0);

        out_ready_i = 1'b0;
        drive(1'b1, 1'b1, 5'd4, 32'h44); tick();
        chk("pp_pre_count", count_o, 1);
        drive(1'b1, 1'b1, 5'd6, 32'h66);
        out_ready_i = 1'b1;
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0);
        chk("pp_count", count_o, 1);
        chk("pp_head_waddr", reg_waddr_o, 6);
        chk("pp_head_wdata", reg_wdata_o, 32'h66);
        tick();
        chk("pp_drain", count_o, 0);

        out_ready_i = 1'b0;
        drive(1'b1, 1'b1, 5'd7, 32'h70); tick();
        drive(1'b1, 1'b1, 5'd7, 32'h77); tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0);
        fwd_raddr1_i = 5'd7;
        fwd_raddr2_i = 5'd8;
        #1;
        chk("fwd_hit1", fwd_hit1_o, 1);
        chk("fwd_data1_young", fwd_data1_o, 32'h77);
        chk("fwd_hit2_miss", fwd_hit2_o, 0);
        chk("fwd_data2_miss", fwd_data2_o, 0);
        chk("head_older", reg_wdata_o, 32'h70);
        out_ready_i = 1'b1;
        tick();
        chk("fwd_after_pop", fwd_data1_o, 32'h77);
        tick();
        chk("fwd_empty_hit", fwd_hit1_o, 0);

        out_ready_i = 1'b0;
        drive(1'b1, 1'b1, 5'd0, 32'hFF); tick();
        drive(1'b1, 1'b0, 5'd9, 32'h99); tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0);
        fwd_raddr1_i = 5'd0;
        fwd_raddr2_i = 5'd9;
        #1;
        chk("x0_fwd_miss", fwd_hit1_o, 0);
        chk("we0_fwd_miss", fwd_hit2_o, 0);
        chk("x0_we", reg_we_o, 0);
        chk("x0_wdata", reg_wdata_o, 32'hFF);
        out_ready_i = 1'b1;
        tick();
        chk("we0_we", reg_we_o, 0);
        chk("we0_waddr", reg_waddr_o, 9);
        chk("we0_wdata", reg_wdata_o, 32'h99);
        tick();

        out_ready_i = 1'b0;
        drive(1'b1, 1'b1, 5'd10, 32'hA0); tick();
        drive(1'b1, 1'b1, 5'd11, 32'hB0); tick();
        fwd_raddr1_i = 5'd10;
        flush_i = 1'b1;
        out_ready_i = 1'b1;
        tick();
        flush_i = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 32'h0);
        chk("flush_count", count_o, 0);
        chk("flush_valid", out_valid_o, 0);
        chk("flush_fwd", fwd_hit1_o, 0);
        chk("flush_wdata", reg_wdata_o, 0);
        out_ready_i = 1'b0;
        drive(1'b1, 1'b1, 5'd12, 32'hC0); tick();
        flush_i = 1'b1;
        drive(1'b1, 1'b1, 5'd13, 32'hD0);
        tick();
        flush_i = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 32'h0);
        chk("flush_over_push", count_o, 0);

        drive(1'b1, 1'b1, 5'd14, 32'hE0); tick();
        drive(1'b1, 1'b1, 5'd15, 32'hF0); tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0);
        chk("pre_areset_count", count_o, 2);
        #2 rst_i = 1'b0;
        #1;
        chk("areset_count", count_o, 0);
        chk("areset_valid", out_valid_o, 0);
        chk("areset_in_ready", in_ready_o, 1);
        chk("areset_wdata", reg_wdata_o, 0);
        #3 rst_i = 1'b1;
        tick();
        $display("%0d/%0d checks passed", n_chk - n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/ex_wb_buffer.md
Name: ex_wb_buffer

Overview:
Two-entry elastic buffer between the execute stage and register-file writeback. It captures each execute result (write enable, destination register, write data) under a valid/ready handshake and presents results to writeback in order. It decouples writeback stalls from execute and exposes two forwarding lookup ports so decode/execute can read pending results before they retire.

Parameters:
DATA_WIDTH, 32, width of write data and forwarded data
RADDR_WIDTH, 5, width of register address
DEPTH, 2, number of entries (fixed at 2; other values unsupported)

Ports:
clk_i  input  1  clock, rising-edge
rst_i  input  1  asynchronous reset, active-low
flush_i  input  1  synchronous flush of all entries
in_valid_i  input  1  execute result valid
in_ready_o  output  1  buffer can accept
reg_we_i  input  1  execute write enable
reg_waddr_i  input  RADDR_WIDTH  execute destination register
reg_wdata_i  input  DATA_WIDTH  execute result
out_valid_o  output  1  head entry valid
out_ready_i  input  1  writeback accepts head
reg_we_o  output  1  head write enable
reg_waddr_o  output  RADDR_WIDTH  head destination register
reg_wdata_o  output  DATA_WIDTH  head write data
fwd_raddr1_i  input  RADDR_WIDTH  lookup address, port 1
fwd_hit1_o  output  1  pending write to fwd_raddr1_i exists
fwd_data1_o  output  DATA_WIDTH  youngest pending data for port 1
fwd_raddr2_i  input  RADDR_WIDTH  lookup address, port 2
fwd_hit2_o  output  1  pending write to fwd_raddr2_i exists
fwd_data2_o  output  DATA_WIDTH  youngest pending data for port 2
count_o  output  2  occupancy, 0..2

Behaviour:
- Reset (rst_i=0, async): count=0, rd/wr pointers=0, all entry fields=0. Outputs: in_ready_o=1, out_valid_o=0, reg_we_o=0, reg_waddr_o=0, reg_wdata_o=0, fwd_hit*=0, fwd_data*=0, count_o=0.
- Storage: circular buffer, 2 entries, 1-bit wr_ptr/rd_ptr, 2-bit count.
- in_ready_o = (count != 2); derived from state only, no combinational path from out_ready_i or in_valid_i.
- out_valid_o = (count != 0). reg_*_o driven from head entry when out_valid_o=1, else forced to 0.
- push = in_valid_i & in_ready_o; pop = out_valid_o & out_ready_i.
- On push, store {reg_we_i & (reg_waddr_i != 0), reg_waddr_i, reg_wdata_i}. Writes to x0 are kept in order with we cleared. Entries with we=0 are buffered, not dropped.
- Latency: an entry pushed at edge N is visible on outputs after edge N when the buffer was empty. Throughput is 1/cycle when out_ready_i=1.
- Push with pop: count=1 -> count stays 1, head becomes the new entry. count=0 -> push only (pop impossible). count=2 -> pop only (in_ready_o=0).
- Head data stays stable while out_valid_o=1 and out_ready_i=0.
- flush_i=1 at an edge: count=0 and pointers=0; it overrides any push or pop in that cycle. Outputs go idle the next cycle. Entry contents may be left stale but must never be visible.
- Forwarding (combinational): port k hits if a valid entry has we=1 and waddr == fwd_raddrk_i. Address 0 never hits. When both entries match, the youngest (most recently pushed) wins. On a miss, fwd_data=0. The incoming in_* beat is not searched.
- No overflow or underflow is possible through the handshake. in_valid_i while in_ready_o=0 is ignored and the input holder must retain its data.
- Reset mid-operation discards all entries immediately, without waiting for a clock.

Test Plan:
- Reset/idle: assert rst_i=0 with in_valid_i=1 -> out_valid_o=0, in_ready_o=1, count_o=0. Release reset, push {we=1,x5,0x0000_00AA} with out_ready_i=1 -> next cycle out_valid_o=1, reg_waddr_o=5, reg_wdata_o=0xAA, then pops.
- Backpressure fill: out_ready_i=0, push x1=0x11 then x2=0x22 -> count_o=2, in_ready_o=0. A third push of x3 is ignored. Raise out_ready_i -> outputs x1/0x11 then x2/0x22 in order, count_o returns to 0.
- Simultaneous push/pop at count 1: head x4=0x44, push x6=0x66 with out_ready_i=1 -> count_o stays 1, next head x6/0x66.
- Forwarding priority: buffer holds x7=0x70 (older) and x7=0x77 (younger), fwd_raddr1_i=7 -> hit1=1, data1=0x77. fwd_raddr2_i=8 -> hit2=0, data2=0.
- x0 and we=0: push {we=1,x0,0xFF} and {we=0,x9,0x99} -> both emerge in order with reg_we_o=0. Forward lookups for x0 and x9 miss.
- Flush: count 2, assert flush_i together with in_valid_i=1 and out_ready_i=1 -> next cycle count_o=0, out_valid_o=0, fwd hits 0. Async reset asserted at count 2 mid-cycle -> outputs clear immediately.
